// File: rtl/fpnew_pkg.sv
// Shared FPnew definitions used by the iterative mantissa divide/sqrt engine.
package fpnew_pkg;

    typedef enum logic [1:0] {
        FmtFp32    = 2'b00,
        FmtFp64    = 2'b01,
        FmtFp16    = 2'b10,
        FmtFp16Alt = 2'b11
    } divsqrt_fmt_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } divsqrt_state_e;

    // Precision p including the hidden bit.
    function automatic int unsigned divsqrt_prec(divsqrt_fmt_e fmt);
        int unsigned prec;
        case (fmt)
            FmtFp32:    prec = 24;
            FmtFp64:    prec = 53;
            FmtFp16:    prec = 11;
            FmtFp16Alt: prec = 8;
            default:    prec = 53;
        endcase
        return prec;
    endfunction

    // p result bits plus one guard and one round bit.
    function automatic int unsigned divsqrt_iters(divsqrt_fmt_e fmt);
        return divsqrt_prec(fmt) + 2;
    endfunction

endpackage

// File: rtl/fpnew_divsqrt_rec_step.sv
// One restoring recurrence step shared by division and square root:
// compare, conditionally subtract, then shift the remainder left by one.
module fpnew_divsqrt_rec_step #(
    parameter int unsigned RemWidth = 56
) (
    input  logic [RemWidth-1:0] i_rem,
    input  logic [RemWidth-1:0] i_divisor,
    input  logic [RemWidth-1:0] i_root,
    input  logic [RemWidth-1:0] i_root_lsb,
    input  logic                i_is_sqrt,
    output logic [RemWidth-1:0] o_rem,
    output logic                o_bit
);

    logic [RemWidth-1:0] w_trial;
    logic [RemWidth-1:0] w_diff;

    always_comb begin
        // Sqrt trial term is 2*Q + 2^-i; the new bit never overlaps the bits of 2*Q.
        w_trial = i_is_sqrt ? (i_root | i_root_lsb) : i_divisor;
        o_bit   = (i_rem >= w_trial);
        w_diff  = o_bit ? (i_rem - w_trial) : i_rem;
        o_rem   = {w_diff[RemWidth-2:0], 1'b0};
    end

endmodule

// File: rtl/fpnew_divsqrt_mant_iter.sv
// Iterative radix-2 mantissa divide/square-root engine, one result bit per cycle,
// answering the start/ready/done/kill handshake of the FPnew divsqrt wrapper.
module fpnew_divsqrt_mant_iter
    import fpnew_pkg::*;
#(
    parameter  int unsigned MantWidth = 53,
    localparam int unsigned QuotWidth = MantWidth + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 div_start_i,
    input  logic                 sqrt_start_i,
    input  logic                 kill_i,
    input  logic [1:0]           fmt_i,
    input  logic [MantWidth-1:0] op_a_i,
    input  logic [MantWidth-1:0] op_b_i,
    input  logic                 sqrt_odd_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic [QuotWidth-1:0] quot_o,
    output logic                 sticky_o
);

    localparam int unsigned RemWidth = MantWidth + 3;
    localparam int unsigned CntWidth = $clog2(QuotWidth + 1);
    localparam logic [CntWidth-1:0] MantPos = CntWidth'(MantWidth);
    localparam logic [CntWidth-1:0] QuotTop = CntWidth'(QuotWidth - 1);

    divsqrt_state_e      r_state;
    divsqrt_state_e      w_state_next;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] r_iters;
    logic                r_is_sqrt;
    logic [RemWidth-1:0] r_rem;
    logic [RemWidth-1:0] r_div;
    logic [QuotWidth-1:0] r_quot;
    logic [QuotWidth-1:0] r_res;
    logic                r_sticky;

    logic                w_ready;
    logic                w_done;
    logic                w_start;
    logic                w_accept;
    logic                w_busy_step;
    logic                w_last_step;
    logic [CntWidth-1:0] w_lsb_sh;
    logic [CntWidth-1:0] w_quot_sh;
    logic [RemWidth-1:0] w_root_lsb;
    logic [RemWidth-1:0] w_rem_next;
    logic                w_bit;
    logic [QuotWidth-1:0] w_quot_next;

    assign w_start     = div_start_i | sqrt_start_i;
    assign w_accept    = w_ready & w_start & ~kill_i;
    assign w_busy_step = (r_state == StBusy) & ~kill_i;
    assign w_last_step = (r_state == StBusy) && (r_cnt == r_iters - CntWidth'(1));

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_ready = 1'b1;
                if (w_start) w_state_next = StBusy;
            end
            StBusy: begin
                if (w_last_step) w_state_next = StDone;
            end
            StDone: begin
                w_ready      = 1'b1;
                w_done       = 1'b1;
                w_state_next = w_start ? StBusy : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        if (kill_i) w_state_next = StIdle;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    // Remainder units are 2^-MantWidth, so the sqrt term 2^-i sits at bit MantWidth-i.
    // Past that range it rounds up to one LSB, which leaves bit and sticky unchanged.
    always_comb begin
        w_lsb_sh    = (r_cnt <= MantPos) ? (MantPos - r_cnt) : '0;
        w_quot_sh   = QuotTop - r_cnt;
        w_root_lsb  = {{(RemWidth-1){1'b0}}, 1'b1} << w_lsb_sh;
        w_quot_next = r_quot | ({{(QuotWidth-1){1'b0}}, w_bit} << w_quot_sh);
    end

    // r_quot read as 2^-MantWidth units equals twice the partial root.
    fpnew_divsqrt_rec_step #(
        .RemWidth (RemWidth)
    ) u_rec_step (
        .i_rem      (r_rem),
        .i_divisor  (r_div),
        .i_root     ({1'b0, r_quot}),
        .i_root_lsb (w_root_lsb),
        .i_is_sqrt  (r_is_sqrt),
        .o_rem      (w_rem_next),
        .o_bit      (w_bit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_iters   <= '0;
            r_is_sqrt <= 1'b0;
            r_rem     <= '0;
            r_div     <= '0;
            r_quot    <= '0;
            r_res     <= '0;
            r_sticky  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_iters   <= CntWidth'(divsqrt_iters(divsqrt_fmt_e'(fmt_i)));
            r_is_sqrt <= ~div_start_i;
            r_div     <= {2'b00, op_b_i, 1'b0};
            r_quot    <= '0;
            if (~div_start_i && sqrt_odd_i) r_rem <= {1'b0, op_a_i, 2'b00};
            else                            r_rem <= {2'b00, op_a_i, 1'b0};
        end else if (w_busy_step) begin
            r_cnt  <= r_cnt + CntWidth'(1);
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
            // Result registers change only on completion so a kill leaves them intact.
            if (w_last_step) begin
                r_res    <= w_quot_next;
                r_sticky <= |w_rem_next;
            end
        end
    end

    assign ready_o  = w_ready;
    assign done_o   = w_done;
    assign quot_o   = r_res;
    assign sticky_o = r_sticky;

endmodule

// File: tb/tb_fpnew_divsqrt_mant_iter.sv
// Directed and randomized bench for the mantissa divide/sqrt engine, checked against
// an arithmetic reference (truncated quotient, integer square root).
module tb_fpnew_divsqrt_mant_iter;

    localparam int W  = 53;
    localparam int QW = 55;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          div_start = 1'b0;
    logic          sqrt_start = 1'b0;
    logic          kill = 1'b0;
    logic [1:0]    fmt = 2'b00;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          sqrt_odd = 1'b0;
    logic          ready;
    logic          done;
    logic [QW-1:0] quot;
    logic          sticky;

    int n_checks = 0;
    int n_pass   = 0;

    fpnew_divsqrt_mant_iter #(
        .MantWidth (W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .div_start_i  (div_start),
        .sqrt_start_i (sqrt_start),
        .kill_i       (kill),
        .fmt_i        (fmt),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .sqrt_odd_i   (sqrt_odd),
        .ready_o      (ready),
        .done_o       (done),
        .quot_o       (quot),
        .sticky_o     (sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int iters_of(input logic [1:0] f);
        case (f)
            2'b00:   return 26;
            2'b01:   return 55;
            2'b10:   return 13;
            default: return 10;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_mant(input int p);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v = v >> (64 - p);
        v[p-1] = 1'b1;
        return W'(v) << (W - p);
    endfunction

    // Division: floor(a * 2^(it-1) / b). Sqrt: largest q with q^2 <= X * 2^(2*(it-1)).
    task automatic ref_model(input bit is_sqrt, input logic [1:0] f, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit odd,
                             output logic [QW-1:0] q, output logic s);
        int it;
        int p;
        logic [127:0] num;
        logic [127:0] qi;
        logic [127:0] n;
        logic [127:0] t;
        it = iters_of(f);
        p  = it - 2;
        if (!is_sqrt) begin
            if (b == '0) begin
                qi = (128'd1 << it) - 128'd1;
                s  = 1'b0;
            end else begin
                num = 128'(a) << (it - 1);
                qi  = num / 128'(b);
                s   = (num % 128'(b)) != 128'd0;
            end
        end else begin
            n = (128'(a) >> (W - p)) << (p + 3);
            if (odd) n = n << 1;
            qi = '0;
            for (int k = it - 1; k >= 0; k--) begin
                t = qi | (128'd1 << k);
                if (t * t <= n) qi = t;
            end
            s = (qi * qi) != n;
        end
        q = QW'(qi << (QW - it));
    endtask

    // Call #1 after an edge; returns #1 after the edge on which done_o rose.
    task automatic run_op(input string tag, input bit is_sqrt, input logic [1:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit odd,
                          input bit both, output logic [QW-1:0] exp_q, output logic exp_s);
        int cycles;
        ref_model(is_sqrt, f, a, b, odd, exp_q, exp_s);
        fmt        = f;
        op_a       = a;
        op_b       = b;
        sqrt_odd   = odd;
        div_start  = !is_sqrt;
        sqrt_start = is_sqrt || both;
        @(posedge clk);
        #1;
        div_start  = 1'b0;
        sqrt_start = 1'b0;
        fmt        = 2'($urandom);
        op_a       = W'({$urandom, $urandom});
        op_b       = W'({$urandom, $urandom});
        sqrt_odd   = ~odd;
        check({tag, "_ready_low"}, 128'(ready), 128'd0);
        cycles = 0;
        while (!done && cycles < 80) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 128'(cycles), 128'(iters_of(f)));
        check({tag, "_quot"}, 128'(quot), 128'(exp_q));
        check({tag, "_sticky"}, 128'(sticky), 128'(exp_s));
    endtask

    initial begin
        logic [QW-1:0] eq;
        logic          es;
        logic [QW-1:0] hold_q;
        logic          hold_s;
        logic [1:0]    rf;
        bit            rs;
        bit            saw_done;

        // Reset values
        @(posedge clk);
        #1;
        check("rst_ready", 128'(ready), 128'd1);
        check("rst_done", 128'(done), 128'd0);
        check("rst_quot", 128'(quot), 128'd0);
        check("rst_sticky", 128'(sticky), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // FP16 div 1.5 / 1.0
        run_op("fp16_div_a", 1'b0, 2'b10, 53'b11 << 51, 53'b1 << 52, 1'b0, 1'b0, eq, es);
        check("fp16_div_a_const", 128'(quot), 128'(55'b1_1000_0000_0000 << 42));
        @(posedge clk);
        #1;
        check("done_one_cycle", 128'(done), 128'd0);

        // FP16 div 1.0 / 1.5
        run_op("fp16_div_b", 1'b0, 2'b10, 53'b1 << 52, 53'b11 << 51, 1'b0, 1'b0, eq, es);
        check("fp16_div_b_const", 128'(quot), 128'(55'b0_1010_1010_1010 << 42));
        check("fp16_div_b_sticky1", 128'(sticky), 128'd1);
        @(posedge clk);
        #1;

        // FP16 sqrt of 2.25
        run_op("fp16_sqrt", 1'b1, 2'b10, 53'b1001 << 49, '0, 1'b1, 1'b0, eq, es);
        check("fp16_sqrt_const", 128'(quot), 128'(55'b1_1000_0000_0000 << 42));
        @(posedge clk);
        #1;

        // FP64 sqrt of 1.0
        run_op("fp64_sqrt", 1'b1, 2'b01, 53'b1 << 52, '0, 1'b0, 1'b0, eq, es);
        check("fp64_sqrt_const", 128'(quot), 128'd1 << 54);

        // Back-to-back: second start in the done cycle
        run_op("b2b_first", 1'b0, 2'b00, rand_mant(24), rand_mant(24), 1'b0, 1'b0, eq, es);
        run_op("b2b_second", 1'b0, 2'b10, rand_mant(11), rand_mant(11), 1'b0, 1'b0, eq, es);
        @(posedge clk);
        #1;

        // Both starts high: division wins
        run_op("both_starts", 1'b0, 2'b11, rand_mant(8), rand_mant(8), 1'b1, 1'b1, hold_q, hold_s);
        @(posedge clk);
        #1;

        // Kill at edge 5 of an FP32 div
        fmt       = 2'b00;
        op_a      = rand_mant(24);
        op_b      = rand_mant(24);
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_ready", 128'(ready), 128'd1);
        check("kill_done", 128'(done), 128'd0);
        saw_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("kill_no_done", 128'(saw_done), 128'd0);
        check("kill_hold_quot", 128'(quot), 128'(hold_q));
        check("kill_hold_sticky", 128'(sticky), 128'(hold_s));

        // Kill with a start in idle: start ignored
        kill      = 1'b1;
        div_start = 1'b1;
        fmt       = 2'b11;
        @(posedge clk);
        #1;
        kill      = 1'b0;
        div_start = 1'b0;
        check("kill_start_ready", 128'(ready), 128'd1);
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("kill_start_no_done", 128'(saw_done), 128'd0);

        // Asynchronous reset during BUSY
        fmt        = 2'b01;
        op_a       = rand_mant(53);
        sqrt_start = 1'b1;
        @(posedge clk);
        #1;
        sqrt_start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_ready", 128'(ready), 128'd1);
        check("midrst_done", 128'(done), 128'd0);
        check("midrst_quot", 128'(quot), 128'd0);
        check("midrst_sticky", 128'(sticky), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero divisor: all-ones result bits
        run_op("div_by_zero", 1'b0, 2'b00, rand_mant(24), '0, 1'b0, 1'b0, eq, es);
        check("div_by_zero_const", 128'(quot), 128'(((55'd1 << 26) - 55'd1) << 29));
        @(posedge clk);
        #1;

        // Randomized operations, sometimes back-to-back
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rf = 2'($urandom_range(0, 3));
            rs = 1'($urandom);
            ra = rand_mant(iters_of(rf) - 2);
            rb = rand_mant(iters_of(rf) - 2);
            run_op(rs ? "rand_sqrt" : "rand_div", rs, rf, ra, rb, 1'($urandom), 1'b0, eq, es);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
                check("rand_idle_ready", 128'(ready), 128'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpnew_divsqrt_mant_iter.md
Name: fpnew_divsqrt_mant_iter

Overview:
- Iterative radix-2 mantissa divide/square-root engine. It is the responder side of the start/ready/done/kill protocol that the FPnew divsqrt wrapper drives.
- Takes normalized mantissas with the hidden bit, MSB-aligned, and produces one quotient/root bit per cycle plus a sticky bit.
- Exponent handling, special cases and rounding belong to the surrounding FPnew datapath and are outside this block.

Parameters:
- MantWidth, 53, mantissa width including the hidden bit (sized for the widest format).
- QuotWidth, MantWidth+2, result width; localparam, do not change.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- div_start_i  in  1  start a division; accepted only while ready_o=1
- sqrt_start_i  in  1  start a square root; accepted only while ready_o=1
- kill_i  in  1  synchronous abort of any operation
- fmt_i  in  2  precision select: 00 FP32 (p=24), 01 FP64 (p=53), 10 FP16 (p=11), 11 FP16ALT (p=8)
- op_a_i  in  MantWidth  dividend or radicand mantissa in [1,2), hidden bit at MSB, unused LSBs zero
- op_b_i  in  MantWidth  divisor mantissa in [1,2); ignored for sqrt
- sqrt_odd_i  in  1  for sqrt: radicand = op_a_i*2, range [1,4)
- ready_o  out  1  engine can accept a start this cycle
- done_o  out  1  one-cycle pulse; result is valid
- quot_o  out  QuotWidth  quotient/root, MSB weight 2^0, MSB-aligned, unused LSBs zero
- sticky_o  out  1  final partial remainder nonzero

Behaviour:
- ITER(fmt) = p+2: FP32 26, FP64 55, FP16 13, FP16ALT 10.
- fmt_i, operands and the operation type are captured on the accepting edge. Later input changes have no effect.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready_o=1. An accepted start goes to BUSY, loads the remainder/operands, clears quot and the iteration counter.
  - BUSY: ready_o=0. Each edge computes one bit and increments the counter. After ITER edges in BUSY the state goes to DONE.
  - DONE: done_o=1 and ready_o=1 in the same cycle. A start in this cycle is accepted (back-to-back) and goes to BUSY; otherwise the state goes to IDLE.
- Latency: start sampled at edge k gives done_o high in the cycle after edge k+ITER.
- quot_o and sticky_o are held stable from the done cycle until the next accepted start.
- Division (restoring): r0=a. Each step: if r>=b then bit=1, r=r-b; then r<<=1.
  - Bits fill quot_o from the MSB down.
  - The quotient lies in (0.5,2), so the MSB can be 0.
  - sticky_o = (r!=0).
- Sqrt (restoring digit recurrence) on radicand in [1,4). Root is in [1,2), MSB always 1. sticky_o = remainder != 0.
- Remainder register is MantWidth+3 bits wide; no overflow for legal inputs.
- Divisor zero (illegal): each bit computes to 1, giving all-ones result bits. Completes normally, no hang.
- div_start_i and sqrt_start_i both high: division wins.
- kill_i high: next state is IDLE from any state, with priority over a simultaneous start.
  - No done_o pulse is produced.
  - quot_o and sticky_o hold their previous values.
- Reset values: state IDLE, ready_o=1, done_o=0, quot_o=0, sticky_o=0, counter=0. Reset mid-operation aborts without a done pulse.
- Starts while ready_o=0 are ignored.

Decomposition:
- Shared package fpnew_pkg gains:
  - divsqrt_fmt_e, the 2-bit encoding above.
  - function divsqrt_iters(fmt) returning ITER.
  - function divsqrt_prec(fmt).
- One combinational sub-module, fpnew_divsqrt_rec_step:
  - Inputs: remainder, divisor or partial root, op type.
  - Outputs: next remainder and result bit.
- The FSM, counter and result shift register stay in the top module.

Test Plan:
- FP16 div, a=1.5 (op_a MSBs 1100_0000_000), b=1.0, start at edge 0 -> done_o in the cycle after edge 13; quot_o top 13 bits 1_1000_0000_0000; sticky_o=0.
- FP16 div, a=1.0, b=1.5 -> quot_o top 13 bits 0_1010_1010_1010; sticky_o=1.
- FP16 sqrt, op_a=1.125, sqrt_odd_i=1 (radicand 2.25) -> quot_o top 13 bits 1_1000_0000_0000; sticky_o=0. FP64 sqrt, op_a=1.0, sqrt_odd_i=0 -> done after 55 edges; root MSB 1, remaining bits 0, sticky_o=0.
- Back-to-back: second div_start_i asserted in the done cycle -> accepted; ready_o=0 the following cycle; second done_o exactly ITER edges later.
- Kill: kill_i at edge 5 of an FP32 div -> IDLE, ready_o=1 next cycle, no done_o. kill_i together with a start in IDLE -> start ignored.
- Reset mid-operation (rst_i pulsed during BUSY) -> immediately ready_o=1, done_o=0, quot_o=0. b=0 div -> all-ones result bits, done after ITER edges.
